// File: rtl/multi_user_free_queue.sv
// Free-pointer queue for the shared-buffer switch core.
// Holds the indices of unused 4-beat cells of the packet data RAM. After reset it fills itself
// with every cell index (0..DEPTH-1), one per cycle, then raises FQ_act and serves pops/pushes.
// The head pointer is presented show-ahead on ptr_dout_s.
// Optional: define FQ_ERR_FLAG_EN to add sticky fq_underflow / fq_overflow outputs.
module multi_user_free_queue #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9,
  parameter int unsigned PW    = 10,
  parameter int unsigned CW    = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [15:0]   ptr_din,
  input  logic          FQ_wr,
  input  logic          FQ_rd,
  output logic [PW-1:0] ptr_dout_s,
  output logic          ptr_fifo_empty,
  output logic          FQ_act,
  output logic [CW-1:0] FQ_count
`ifdef FQ_ERR_FLAG_EN
  ,
  output logic          fq_underflow,
  output logic          fq_overflow
`endif
);

  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  // StSettle is the one-cycle gap between the last init write and FQ_act rising.
  typedef enum logic [1:0] {StInit, StSettle, StActive} state_e;

  state_e state_q, state_d;

  logic [AW-1:0] mem [DEPTH];

  logic [AW-1:0] rd_p_q, rd_p_d;
  logic [AW-1:0] wr_p_q, wr_p_d;
  logic [AW-1:0] init_q, init_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty_q;

  logic          init_en;
  logic          act_en;
  logic          rd_ok;
  logic          wr_ok;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [AW-1:0] mem_wdata;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: walk the init counter to the last index, settle one cycle, then stay active.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit: begin
        if (init_q == LastIdx) begin
          state_d = StSettle;
        end
      end
      StSettle: state_d = StActive;
      StActive: state_d = StActive;
      default:  state_d = StInit;
    endcase
  end

  // FSM outputs.
  always_comb begin
    init_en = 1'b0;
    act_en  = 1'b0;
    unique case (state_q)
      StInit:   init_en = 1'b1;
      StSettle: ;
      StActive: act_en  = 1'b1;
      default:  ;
    endcase
  end

  assign FQ_act = act_en;

  // Accepted operations. A push while full is taken only alongside an accepted pop.
  always_comb begin
    rd_ok = act_en && FQ_rd && (cnt_q != '0);
    wr_ok = act_en && FQ_wr && ((cnt_q != FullCnt) || rd_ok);
  end

  // Datapath next-state: init fill or normal push/pop bookkeeping.
  always_comb begin
    rd_p_d    = rd_p_q;
    wr_p_d    = wr_p_q;
    init_d    = init_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_p_q;
    mem_wdata = ptr_din[AW-1:0];
    if (init_en) begin
      mem_we    = 1'b1;
      mem_waddr = init_q;
      mem_wdata = init_q;
      init_d    = init_q + AW'(1);
      wr_p_d    = wr_p_q + AW'(1);
      cnt_d     = cnt_q + CW'(1);
    end else begin
      if (wr_ok) begin
        mem_we = 1'b1;
        wr_p_d = wr_p_q + AW'(1);
      end
      if (rd_ok) begin
        rd_p_d = rd_p_q + AW'(1);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer, occupancy and empty registers; empty tracks cnt on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_p_q  <= '0;
      wr_p_q  <= '0;
      init_q  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
    end else begin
      rd_p_q  <= rd_p_d;
      wr_p_q  <= wr_p_d;
      init_q  <= init_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
    end
  end

  // Pointer storage; contents need no reset since init rewrites every entry.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Show-ahead head; forced to zero until the queue is usable and holds something.
  always_comb begin
    ptr_dout_s = '0;
    if (act_en && !empty_q) begin
      ptr_dout_s = PW'(mem[rd_p_q]);
    end
  end

  assign FQ_count       = cnt_q;
  assign ptr_fifo_empty = empty_q;

`ifdef FQ_ERR_FLAG_EN
  logic underflow_q;
  logic overflow_q;

  // Sticky misuse flags, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (act_en) begin
      if (FQ_rd && (cnt_q == '0)) begin
        underflow_q <= 1'b1;
      end
      if (FQ_wr && (cnt_q == FullCnt) && !rd_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign fq_underflow = underflow_q;
  assign fq_overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_multi_user_free_queue.sv
// Self-checking bench for multi_user_free_queue; a queue model holds the expected pointer order.
module tb_multi_user_free_queue;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] ptr_din;
  logic        FQ_wr;
  logic        FQ_rd;
  logic [9:0]  ptr_dout_s;
  logic        ptr_fifo_empty;
  logic        FQ_act;
  logic [9:0]  FQ_count;
`ifdef FQ_ERR_FLAG_EN
  logic        fq_underflow;
  logic        fq_overflow;
`endif

  int total = 0;
  int bad   = 0;
  logic [8:0] model[$];

  always #5 clk = ~clk;

  multi_user_free_queue dut (
    .clk            (clk),
    .rstn           (rstn),
    .ptr_din        (ptr_din),
    .FQ_wr          (FQ_wr),
    .FQ_rd          (FQ_rd),
    .ptr_dout_s     (ptr_dout_s),
    .ptr_fifo_empty (ptr_fifo_empty),
    .FQ_act         (FQ_act),
    .FQ_count       (FQ_count)
`ifdef FQ_ERR_FLAG_EN
    ,
    .fq_underflow   (fq_underflow),
    .fq_overflow    (fq_overflow)
`endif
  );

  // Drive one cycle of stimulus, update the model, and return #1 after the edge with inputs idle.
  task automatic drive(input logic wr, input logic rd, input logic [15:0] din);
    bit rd_ok;
    bit wr_ok;
    rd_ok = rd && (model.size() != 0);
    wr_ok = wr && ((model.size() != 512) || rd_ok);
    if (rd_ok) void'(model.pop_front());
    if (wr_ok) model.push_back(din[8:0]);
    FQ_wr   = wr;
    FQ_rd   = rd;
    ptr_din = din;
    @(posedge clk);
    #1;
    FQ_wr = 1'b0;
    FQ_rd = 1'b0;
  endtask

  // Wait for init after reset release; stray requests during init must be ignored.
  task automatic test_init();
    int edges = 0;
    FQ_wr   = 1'b1;
    FQ_rd   = 1'b1;
    ptr_din = 16'h0007;
    while (FQ_act !== 1'b1 && edges < 600) begin
      @(posedge clk);
      #1;
      edges++;
    end
    FQ_wr = 1'b0;
    FQ_rd = 1'b0;
    model.delete();
    for (int i = 0; i < 512; i++) model.push_back(9'(i));
    total++;
    if (edges != 513) begin
      bad++;
      $display("FAIL init_latency: got %0d edges, expected 513", edges);
    end
    total++;
    if (FQ_count !== 10'd512) begin
      bad++;
      $display("FAIL init_count: got %0d, expected 512", FQ_count);
    end
    total++;
    if (ptr_fifo_empty !== 1'b0) begin
      bad++;
      $display("FAIL init_empty: got %b, expected 0", ptr_fifo_empty);
    end
    total++;
    if (ptr_dout_s !== 10'd0) begin
      bad++;
      $display("FAIL init_head: got %0d, expected 0", ptr_dout_s);
    end
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    FQ_wr   = 1'b0;
    FQ_rd   = 1'b0;
    ptr_din = '0;
    #23;
    total++;
    if (FQ_act !== 1'b0 || FQ_count !== 10'd0 || ptr_fifo_empty !== 1'b1 || ptr_dout_s !== 10'd0)
    begin
      bad++;
      $display("FAIL reset_state: act=%b count=%0d empty=%b head=%0d, expected 0/0/1/0",
               FQ_act, FQ_count, ptr_fifo_empty, ptr_dout_s);
    end
    @(negedge clk);
    rstn = 1'b1;
    test_init();
  endtask

  task automatic test_pop3();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ptr_dout_s !== 10'(i)) begin
        bad++;
        $display("FAIL pop3_head: got %0d, expected %0d", ptr_dout_s, i);
      end
      drive(1'b0, 1'b1, 16'h0);
    end
    total++;
    if (ptr_dout_s !== 10'd3 || FQ_count !== 10'd509) begin
      bad++;
      $display("FAIL pop3_after: head=%0d count=%0d, expected 3/509", ptr_dout_s, FQ_count);
    end
  endtask

  task automatic test_drain();
    logic [9:0] last = '0;
    for (int i = 3; i < 512; i++) begin
      total++;
      if (ptr_dout_s !== 10'(model[0])) begin
        bad++;
        $display("FAIL drain_head: got %0d, expected %0d", ptr_dout_s, model[0]);
      end
      last = ptr_dout_s;
      drive(1'b0, 1'b1, 16'h0);
    end
    total++;
    if (last !== 10'd511) begin
      bad++;
      $display("FAIL drain_last: got %0d, expected 511", last);
    end
    total++;
    if (FQ_count !== 10'd0 || ptr_fifo_empty !== 1'b1) begin
      bad++;
      $display("FAIL drain_empty: count=%0d empty=%b, expected 0/1", FQ_count, ptr_fifo_empty);
    end
    drive(1'b0, 1'b1, 16'h0);
    total++;
    if (FQ_count !== 10'd0 || ptr_fifo_empty !== 1'b1) begin
      bad++;
      $display("FAIL pop_empty: count=%0d empty=%b, expected 0/1", FQ_count, ptr_fifo_empty);
    end
`ifdef FQ_ERR_FLAG_EN
    total++;
    if (fq_underflow !== 1'b1 || fq_overflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_flag: under=%b over=%b, expected 1/0", fq_underflow, fq_overflow);
    end
`endif
  endtask

  task automatic test_push_pop();
    // Upper bits of ptr_din are junk and must be dropped.
    drive(1'b1, 1'b0, 16'hFE05);
    total++;
    if (ptr_dout_s !== 10'h005 || FQ_count !== 10'd1 || ptr_fifo_empty !== 1'b0) begin
      bad++;
      $display("FAIL push_first: head=%0h count=%0d empty=%b, expected 5/1/0",
               ptr_dout_s, FQ_count, ptr_fifo_empty);
    end
    drive(1'b1, 1'b0, 16'h01A3);
    total++;
    if (ptr_dout_s !== 10'h005 || FQ_count !== 10'd2) begin
      bad++;
      $display("FAIL push_second: head=%0h count=%0d, expected 5/2", ptr_dout_s, FQ_count);
    end
    drive(1'b0, 1'b1, 16'h0);
    total++;
    if (ptr_dout_s !== 10'h1A3 || FQ_count !== 10'd1) begin
      bad++;
      $display("FAIL pop_to_second: head=%0h count=%0d, expected 1a3/1", ptr_dout_s, FQ_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 99; i++) drive(1'b1, 1'b0, 16'($urandom_range(0, 65535)));
    total++;
    if (FQ_count !== 10'd100) begin
      bad++;
      $display("FAIL fill_100: got %0d, expected 100", FQ_count);
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (ptr_dout_s !== 10'(model[0])) begin
        bad++;
        $display("FAIL simul_head: got %0d, expected %0d", ptr_dout_s, model[0]);
      end
      drive(1'b1, 1'b1, 16'($urandom_range(0, 65535)));
      total++;
      if (FQ_count !== 10'd100) begin
        bad++;
        $display("FAIL simul_count: got %0d, expected 100", FQ_count);
      end
    end
    for (int i = 0; i < 100; i++) begin
      total++;
      if (ptr_dout_s !== 10'(model[0])) begin
        bad++;
        $display("FAIL simul_order: got %0d, expected %0d", ptr_dout_s, model[0]);
      end
      drive(1'b0, 1'b1, 16'h0);
    end
    total++;
    if (FQ_count !== 10'd0 || ptr_fifo_empty !== 1'b1) begin
      bad++;
      $display("FAIL simul_drain: count=%0d empty=%b, expected 0/1", FQ_count, ptr_fifo_empty);
    end
  endtask

  task automatic test_full_and_midreset();
    for (int i = 0; i < 512; i++) drive(1'b1, 1'b0, 16'((i * 37 + 11) % 512));
    total++;
    if (FQ_count !== 10'd512) begin
      bad++;
      $display("FAIL fill_full: got %0d, expected 512", FQ_count);
    end
    drive(1'b1, 1'b0, 16'h0007);
    total++;
    if (FQ_count !== 10'd512 || ptr_dout_s !== 10'(model[0])) begin
      bad++;
      $display("FAIL push_full: count=%0d head=%0d, expected 512/%0d",
               FQ_count, ptr_dout_s, model[0]);
    end
`ifdef FQ_ERR_FLAG_EN
    total++;
    if (fq_overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_flag: got %b, expected 1", fq_overflow);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      total++;
      if (ptr_dout_s !== 10'(model[0])) begin
        bad++;
        $display("FAIL full_pop_head: got %0d, expected %0d", ptr_dout_s, model[0]);
      end
      drive(1'b0, 1'b1, 16'h0);
    end
    // Reset lands between edges while a pop is being requested.
    FQ_rd = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (FQ_act !== 1'b0 || FQ_count !== 10'd0 || ptr_fifo_empty !== 1'b1 || ptr_dout_s !== 10'd0)
    begin
      bad++;
      $display("FAIL midreset_state: act=%b count=%0d empty=%b head=%0d, expected 0/0/1/0",
               FQ_act, FQ_count, ptr_fifo_empty, ptr_dout_s);
    end
`ifdef FQ_ERR_FLAG_EN
    total++;
    if (fq_underflow !== 1'b0 || fq_overflow !== 1'b0) begin
      bad++;
      $display("FAIL midreset_flags: under=%b over=%b, expected 0/0", fq_underflow, fq_overflow);
    end
`endif
    FQ_rd = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    test_init();
    drive(1'b0, 1'b1, 16'h0);
    total++;
    if (ptr_dout_s !== 10'd1 || FQ_count !== 10'd511) begin
      bad++;
      $display("FAIL reinit_pop: head=%0d count=%0d, expected 1/511", ptr_dout_s, FQ_count);
    end
  endtask

  initial begin
    test_reset();
    test_pop3();
    test_drain();
    test_push_pop();
    test_back_to_back();
    test_full_and_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
